dbus_responder: RTL

DBUS_RESPONDER -- requirements
Module: dbus_responder

---
 rtl/common.sv | 19 +
 rtl/pipes.sv | 13 +
 rtl/byte_en_ram.sv | 29 ++
 rtl/dbus_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared data-bus request/response bundles.
// Used by every block that talks on the core data bus.
package common;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Shared pipeline/state definitions.
// Holds FSM encodings used across bus responder blocks.
package pipes;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dbus_state_t;

  localparam int unsigned LAT_W = 4;

endpackage

// File: rtl/byte_en_ram.sv
// 64-bit word RAM: synchronous byte-enabled write,
// combinational read. Contents are not reset.
module byte_en_ram #(
  parameter int unsigned WORDS = 4096,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [7:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);

  logic [63:0] mem_q [WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_responder.sv
// Data-bus memory responder: one transaction in flight,
// fixed accept-to-response latency, byte-strobed writes.
module dbus_responder
  import common::*;
  import pipes::*;
#(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);

  dbus_state_t      state_q;
  logic [LAT_W-1:0] cnt_q;
  logic [63:0]      addr_q;
  logic [7:0]       strb_q;
  logic [63:0]      data_q;
  logic [31:0]      rd_q, rd_d;
  logic [31:0]      wr_q, wr_d;

  logic [63:0]      off;
  logic             in_rng;
  logic             is_wr;
  logic             resp;
  logic             accept;
  logic             mem_we;
  logic [63:0]      rd_word;

  assign off    = addr_q - BASE_ADDR;
  assign in_rng = (addr_q >= BASE_ADDR)
               && (off[63:3+AW] == '0);
  assign is_wr  = |strb_q;
  assign resp   = (state_q == RESP);
  assign accept = reset && (state_q == IDLE)
               && dreq.valid;
  assign mem_we = resp && is_wr && in_rng;

  assign rd_d = (rd_q == '1) ? rd_q : rd_q + 32'd1;
  assign wr_d = (wr_q == '1) ? wr_q : wr_q + 32'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      strb_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            addr_q <= dreq.addr;
            strb_q <= dreq.strobe;
            data_q <= dreq.data;
            if (LAT != '0) begin
              state_q <= WAIT;
              cnt_q   <= LAT;
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q <= LAT_W'(1)) begin
            state_q <= RESP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - LAT_W'(1);
          end
        end
        RESP: begin
          state_q <= IDLE;
          if (is_wr) wr_q <= wr_d;
          else       rd_q <= rd_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_en_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (strb_q),
    .addr_i  (off[3 +: AW]),
    .wdata_i (data_q),
    .rdata_o (rd_word)
  );

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = accept;
    dresp.data_ok = resp;
    if (resp && !is_wr && in_rng) begin
      dresp.data = rd_word;
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;

  // size is only meaningful to the core's byte extraction
  logic unused_bits;
  assign unused_bits = ^{dreq.size, off[2:0]};

endmodule
